mpu_cmd_sequencer: RTL and testbench
====================================

Name: mpu_cmd_sequencer

Overview:
Parametrised successor to the single-shot MPU controller. It accepts matrix-multiply commands into a FIFO of depth QUEUE_DEPTH. It issues them one at a time to the matrix register file, dispatcher and collector through a four-state FSM. It holds back any command whose source or destination collides with the destination still being written by the collector (RAW/WAW hazard). It sits between the instruction front end and the register file / dispatcher / collector.

Parameters:
ADDR_W, 4, width of matrix register addresses
QUEUE_DEPTH, 4, command FIFO entries; must be a power of 2 and at least 2
CNT_W, 3, width of queue_count_out; equals log2(QUEUE_DEPTH)+1

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cmd_valid_in  in  1  command present on cmd_* inputs
cmd_ready_out  out  1  FIFO can accept; a command is accepted when valid and ready
cmd_src0_in  in  ADDR_W  multiplicand register address
cmd_src1_in  in  ADDR_W  multiplier register address
cmd_dest_in  in  ADDR_W  destination register address
disp_ready_in  in  1  register file grants dispatcher load
collector_ready_in  in  1  register file grants collector store
disp_finished_in  in  1  dispatcher finished the current operation (1-cycle pulse)
collector_active_write_in  in  1  collector is writing results
collector_done_in  in  1  collector completed its final write (1-cycle pulse)
disp_start_out  out  1  1-cycle pulse: start dispersion
reg_disp_req_out  out  1  dispatcher load request
reg_collector_req_out  out  1  collector write request
reg_src_addr_0_out  out  ADDR_W  current multiplicand address
reg_src_addr_1_out  out  ADDR_W  current multiplier address
reg_dest_addr_out  out  ADDR_W  current destination address
busy_out  out  1  FSM not in IDLE, or queue non-empty, or a collector write is pending
queue_count_out  out  CNT_W  number of FIFO occupants, 0..QUEUE_DEPTH

Behaviour:
- Reset: FIFO emptied, FSM to IDLE, pending-write flag cleared. All outputs are 0, except cmd_ready_out, which is 1. Reset overrides any operation in flight, and the queued commands are discarded.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo QUEUE_DEPTH.
  - cmd_ready_out = (count != QUEUE_DEPTH).
  - Simultaneous push and pop when full: the push is refused, because ready is computed from the registered count.
  - Simultaneous push and pop when not full: the count is unchanged.
  - An empty FIFO is never popped.
- Current-command register: loaded from the FIFO head on a pop. It drives the reg_*_addr_out outputs; in IDLE those outputs hold their last value.
- Pending-write tracking:
  - pend_valid is set, and pend_dest is captured from the current destination, on disp_finished_in.
  - pend_valid is cleared on collector_done_in.
  - If both occur in the same cycle, set wins, because done refers to the older write.
- Hazard: head of the FIFO matches pend_dest (src0, src1 or dest) while pend_valid is 1.
- FSM states:
  - IDLE: if the FIFO is non-empty and there is no hazard, pop and go to REQ next cycle. If there is a hazard, stay.
  - REQ: reg_disp_req_out=1. When disp_ready_in & collector_ready_in are both 1, go to START.
  - START: disp_start_out=1 for exactly this cycle; reg_disp_req_out stays 1. Go to RUN.
  - RUN: reg_disp_req_out=1. On disp_finished_in, go to IDLE.
- Latency: from a command accepted into an empty, hazard-free FIFO to disp_start_out is 3 cycles (pop at +1, REQ at +2, START at +3), assuming the grants are already high.
- disp_finished_in outside RUN is ignored for FSM purposes; it still sets pend_valid only when in RUN.
- reg_collector_req_out = collector_active_write_in (combinational pass-through).
- Back-to-back operation: the next command may start REQ while the previous collector write is still pending, provided there is no hazard.

Test Plan:
- Single command: push src0=1, src1=2, dest=3 with grants high -> disp_start_out pulses exactly 3 cycles after acceptance; reg_*_addr_out = 1/2/3; after disp_finished_in, FSM returns to IDLE; busy_out stays high until collector_done_in.
- Fill queue: push 5 commands while the FSM is stalled in REQ (disp_ready_in=0) -> 1 is popped and 4 are queued; cmd_ready_out=0 and queue_count_out=4; 6th push refused; wrap-around order preserved across 8 total commands.
- RAW hazard: cmd A dest=5, cmd B src1=5 -> B is not popped until collector_done_in of A; B's disp_start_out occurs 3 cycles after done.
- No hazard: cmd A dest=5, cmd B dest=6 with sources 0/1 -> B enters REQ the cycle after A's disp_finished_in, while A's collector write is still active.
- Grant withholding: collector_ready_in toggles low in REQ -> no disp_start_out until both grants are high in the same cycle; the pulse is exactly 1 cycle wide.
- Reset in RUN with 2 commands queued -> next cycle: queue_count_out=0, all outputs 0 except cmd_ready_out=1, and no stale disp_start_out afterwards.

Source files
------------

// File: rtl/mpu_cmd_sequencer.sv
// Matrix-multiply command sequencer: queues commands in a small FIFO and issues
// them one at a time to the register file, dispatcher and collector, holding
// back any command that reads or writes the destination still being collected.
module mpu_cmd_sequencer #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned CNT_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_in,
    output logic              cmd_ready_out,
    input  logic [ADDR_W-1:0] cmd_src0_in,
    input  logic [ADDR_W-1:0] cmd_src1_in,
    input  logic [ADDR_W-1:0] cmd_dest_in,
    input  logic              disp_ready_in,
    input  logic              collector_ready_in,
    input  logic              disp_finished_in,
    input  logic              collector_active_write_in,
    input  logic              collector_done_in,
    output logic              disp_start_out,
    output logic              reg_disp_req_out,
    output logic              reg_collector_req_out,
    output logic [ADDR_W-1:0] reg_src_addr_0_out,
    output logic [ADDR_W-1:0] reg_src_addr_1_out,
    output logic [ADDR_W-1:0] reg_dest_addr_out,
    output logic              busy_out,
    output logic [CNT_W-1:0]  queue_count_out
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, REQ, START, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fifo_src0 [QUEUE_DEPTH];
    logic [ADDR_W-1:0] fifo_src1 [QUEUE_DEPTH];
    logic [ADDR_W-1:0] fifo_dest [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_dest;
    logic              push;
    logic              pop;
    logic              hazard;
    logic [ADDR_W-1:0] head_src0;
    logic [ADDR_W-1:0] head_src1;
    logic [ADDR_W-1:0] head_dest;

    assign head_src0 = fifo_src0[rd_ptr];
    assign head_src1 = fifo_src1[rd_ptr];
    assign head_dest = fifo_dest[rd_ptr];

    // Ready comes from the registered count, so a push into a full FIFO is
    // refused even when a pop happens in the same cycle.
    assign cmd_ready_out   = (count != CNT_W'(QUEUE_DEPTH));
    assign push            = cmd_valid_in && cmd_ready_out;
    assign hazard          = pend_valid && ((head_src0 == pend_dest) ||
                                            (head_src1 == pend_dest) ||
                                            (head_dest == pend_dest));
    assign pop             = (state == IDLE) && (count != '0) && !hazard;
    assign queue_count_out = count;
    assign busy_out        = (state != IDLE) || (count != '0) || pend_valid;
    assign reg_collector_req_out = collector_active_write_in;

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_src0[wr_ptr] <= cmd_src0_in;
            fifo_src1[wr_ptr] <= cmd_src1_in;
            fifo_dest[wr_ptr] <= cmd_dest_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Pending collector write; a new finish wins over a done for the older write.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_dest  <= '0;
        end else if ((state == RUN) && disp_finished_in) begin
            pend_valid <= 1'b1;
            pend_dest  <= reg_dest_addr_out;
        end else if (collector_done_in) begin
            pend_valid <= 1'b0;
        end
    end

    // Issue FSM with registered request/start outputs and current-command register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            disp_start_out     <= 1'b0;
            reg_disp_req_out   <= 1'b0;
            reg_src_addr_0_out <= '0;
            reg_src_addr_1_out <= '0;
            reg_dest_addr_out  <= '0;
        end else begin
            disp_start_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        reg_src_addr_0_out <= head_src0;
                        reg_src_addr_1_out <= head_src1;
                        reg_dest_addr_out  <= head_dest;
                        reg_disp_req_out   <= 1'b1;
                        state              <= REQ;
                    end
                end
                REQ: begin
                    if (disp_ready_in && collector_ready_in) begin
                        disp_start_out <= 1'b1;
                        state          <= START;
                    end
                end
                START: begin
                    state <= RUN;
                end
                RUN: begin
                    if (disp_finished_in) begin
                        reg_disp_req_out <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_cmd_sequencer.sv
// Directed bench for mpu_cmd_sequencer with hand-computed expectations.
module tb_mpu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid_in;
    logic       cmd_ready_out;
    logic [3:0] cmd_src0_in;
    logic [3:0] cmd_src1_in;
    logic [3:0] cmd_dest_in;
    logic       disp_ready_in;
    logic       collector_ready_in;
    logic       disp_finished_in;
    logic       collector_active_write_in;
    logic       collector_done_in;
    logic       disp_start_out;
    logic       reg_disp_req_out;
    logic       reg_collector_req_out;
    logic [3:0] reg_src_addr_0_out;
    logic [3:0] reg_src_addr_1_out;
    logic [3:0] reg_dest_addr_out;
    logic       busy_out;
    logic [2:0] queue_count_out;

    int errors = 0;
    int checks = 0;

    logic [3:0] t_s0 [8];
    logic [3:0] t_s1 [8];
    logic [3:0] t_d  [8];

    mpu_cmd_sequencer #(
        .ADDR_W      (4),
        .QUEUE_DEPTH (4),
        .CNT_W       (3)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .cmd_valid_in              (cmd_valid_in),
        .cmd_ready_out             (cmd_ready_out),
        .cmd_src0_in               (cmd_src0_in),
        .cmd_src1_in               (cmd_src1_in),
        .cmd_dest_in               (cmd_dest_in),
        .disp_ready_in             (disp_ready_in),
        .collector_ready_in        (collector_ready_in),
        .disp_finished_in          (disp_finished_in),
        .collector_active_write_in (collector_active_write_in),
        .collector_done_in         (collector_done_in),
        .disp_start_out            (disp_start_out),
        .reg_disp_req_out          (reg_disp_req_out),
        .reg_collector_req_out     (reg_collector_req_out),
        .reg_src_addr_0_out        (reg_src_addr_0_out),
        .reg_src_addr_1_out        (reg_src_addr_1_out),
        .reg_dest_addr_out         (reg_dest_addr_out),
        .busy_out                  (busy_out),
        .queue_count_out           (queue_count_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] d);
        cmd_valid_in = 1'b1;
        cmd_src0_in  = s0;
        cmd_src1_in  = s1;
        cmd_dest_in  = d;
        step();
        cmd_valid_in = 1'b0;
    endtask

    task automatic pulse_finished();
        disp_finished_in = 1'b1;
        step();
        disp_finished_in = 1'b0;
    endtask

    task automatic pulse_done();
        collector_done_in = 1'b1;
        step();
        collector_done_in = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!disp_start_out && n < 20) begin
            step();
            n++;
        end
        check_eq(tag, 32'(disp_start_out), 32'd1);
    endtask

    // Wait for the next start, check its addresses, then finish and retire it.
    task automatic run_one(input int k);
        wait_start("fill_start_seen");
        check_eq("fill_order_src0", 32'(reg_src_addr_0_out), 32'(t_s0[k]));
        check_eq("fill_order_src1", 32'(reg_src_addr_1_out), 32'(t_s1[k]));
        check_eq("fill_order_dest", 32'(reg_dest_addr_out), 32'(t_d[k]));
        step();
        pulse_finished();
        pulse_done();
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid_in = 1'b0;
        cmd_src0_in = '0;
        cmd_src1_in = '0;
        cmd_dest_in = '0;
        disp_ready_in = 1'b1;
        collector_ready_in = 1'b1;
        disp_finished_in = 1'b0;
        collector_active_write_in = 1'b0;
        collector_done_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            t_s0[k] = 4'(k + 1);
            t_s1[k] = 4'(k + 4);
            t_d[k]  = 4'(k + 8);
        end
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_eq("rst_ready", 32'(cmd_ready_out), 32'd1);
        check_eq("rst_count", 32'(queue_count_out), 32'd0);
        check_eq("rst_busy", 32'(busy_out), 32'd0);
        check_eq("rst_start", 32'(disp_start_out), 32'd0);
        check_eq("rst_req", 32'(reg_disp_req_out), 32'd0);

        // Single command: start exactly 3 cycles after acceptance
        push(4'd1, 4'd2, 4'd3);
        check_eq("single_count1", 32'(queue_count_out), 32'd1);
        check_eq("single_start_c1", 32'(disp_start_out), 32'd0);
        step();
        check_eq("single_req_c2", 32'(reg_disp_req_out), 32'd1);
        check_eq("single_start_c2", 32'(disp_start_out), 32'd0);
        check_eq("single_count_pop", 32'(queue_count_out), 32'd0);
        step();
        check_eq("single_start_c3", 32'(disp_start_out), 32'd1);
        check_eq("single_src0", 32'(reg_src_addr_0_out), 32'd1);
        check_eq("single_src1", 32'(reg_src_addr_1_out), 32'd2);
        check_eq("single_dest", 32'(reg_dest_addr_out), 32'd3);
        step();
        check_eq("single_start_c4", 32'(disp_start_out), 32'd0);
        check_eq("single_req_run", 32'(reg_disp_req_out), 32'd1);
        collector_active_write_in = 1'b1;
        pulse_finished();
        check_eq("single_req_idle", 32'(reg_disp_req_out), 32'd0);
        check_eq("single_busy_pend", 32'(busy_out), 32'd1);
        check_eq("single_coll_req", 32'(reg_collector_req_out), 32'd1);
        step();
        check_eq("single_busy_hold", 32'(busy_out), 32'd1);
        collector_active_write_in = 1'b0;
        pulse_done();
        check_eq("single_busy_done", 32'(busy_out), 32'd0);
        check_eq("single_coll_req0", 32'(reg_collector_req_out), 32'd0);
        check_eq("single_addr_hold", 32'(reg_dest_addr_out), 32'd3);

        // Fill queue while stalled in REQ, refuse sixth, keep order across wrap
        disp_ready_in = 1'b0;
        for (int k = 0; k < 5; k++) push(t_s0[k], t_s1[k], t_d[k]);
        check_eq("fill_count4", 32'(queue_count_out), 32'd4);
        check_eq("fill_ready0", 32'(cmd_ready_out), 32'd0);
        check_eq("fill_req_stall", 32'(reg_disp_req_out), 32'd1);
        push(t_s0[5], t_s1[5], t_d[5]);
        check_eq("fill_refused", 32'(queue_count_out), 32'd4);
        disp_ready_in = 1'b1;
        for (int k = 0; k < 5; k++) run_one(k);
        check_eq("fill_drained", 32'(queue_count_out), 32'd0);
        for (int k = 5; k < 8; k++) push(t_s0[k], t_s1[k], t_d[k]);
        for (int k = 5; k < 8; k++) run_one(k);

        // RAW hazard: B reads A's destination and waits for A's done
        push(4'd8, 4'd9, 4'd5);
        push(4'd10, 4'd5, 4'd11);
        wait_start("raw_a_start");
        step();
        pulse_finished();
        for (int i = 0; i < 4; i++) step();
        check_eq("raw_b_held_count", 32'(queue_count_out), 32'd1);
        check_eq("raw_b_held_req", 32'(reg_disp_req_out), 32'd0);
        pulse_done();
        check_eq("raw_d1_start", 32'(disp_start_out), 32'd0);
        step();
        check_eq("raw_d2_req", 32'(reg_disp_req_out), 32'd1);
        check_eq("raw_d2_start", 32'(disp_start_out), 32'd0);
        step();
        check_eq("raw_d3_start", 32'(disp_start_out), 32'd1);
        check_eq("raw_b_src1", 32'(reg_src_addr_1_out), 32'd5);
        check_eq("raw_b_dest", 32'(reg_dest_addr_out), 32'd11);
        step();
        pulse_finished();
        pulse_done();

        // No hazard: B issues while A's collector write is still active
        push(4'd0, 4'd1, 4'd5);
        push(4'd0, 4'd1, 4'd6);
        wait_start("nohaz_a_start");
        step();
        collector_active_write_in = 1'b1;
        pulse_finished();
        check_eq("nohaz_f1_req", 32'(reg_disp_req_out), 32'd0);
        step();
        check_eq("nohaz_b_req", 32'(reg_disp_req_out), 32'd1);
        check_eq("nohaz_b_dest", 32'(reg_dest_addr_out), 32'd6);
        check_eq("nohaz_coll_active", 32'(reg_collector_req_out), 32'd1);
        check_eq("nohaz_busy", 32'(busy_out), 32'd1);
        collector_active_write_in = 1'b0;
        pulse_done();
        wait_start("nohaz_b_start");
        step();
        pulse_finished();
        pulse_done();

        // Grant withholding: start only when both grants are high together
        collector_ready_in = 1'b0;
        push(4'd2, 4'd3, 4'd4);
        step();
        step();
        step();
        check_eq("grant_coll_low_start", 32'(disp_start_out), 32'd0);
        check_eq("grant_coll_low_req", 32'(reg_disp_req_out), 32'd1);
        disp_ready_in = 1'b0;
        collector_ready_in = 1'b1;
        step();
        step();
        check_eq("grant_disp_low_start", 32'(disp_start_out), 32'd0);
        disp_ready_in = 1'b1;
        step();
        check_eq("grant_both_start", 32'(disp_start_out), 32'd1);
        step();
        check_eq("grant_pulse_width", 32'(disp_start_out), 32'd0);
        pulse_finished();
        pulse_done();

        // Reset during RUN with two commands queued
        push(4'd1, 4'd2, 4'd3);
        push(4'd4, 4'd5, 4'd6);
        push(4'd7, 4'd8, 4'd9);
        wait_start("rstrun_start");
        step();
        check_eq("rstrun_count2", 32'(queue_count_out), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rstrun_count", 32'(queue_count_out), 32'd0);
        check_eq("rstrun_ready", 32'(cmd_ready_out), 32'd1);
        check_eq("rstrun_req", 32'(reg_disp_req_out), 32'd0);
        check_eq("rstrun_busy", 32'(busy_out), 32'd0);
        check_eq("rstrun_src0", 32'(reg_src_addr_0_out), 32'd0);
        check_eq("rstrun_src1", 32'(reg_src_addr_1_out), 32'd0);
        check_eq("rstrun_dest", 32'(reg_dest_addr_out), 32'd0);
        check_eq("rstrun_coll_req", 32'(reg_collector_req_out), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check_eq("rstrun_no_stale_start", 32'(disp_start_out), 32'd0);
            step();
        end
        check_eq("rstrun_idle_req", 32'(reg_disp_req_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
